// File: rtl/output_pkg.sv
// rtl/output_pkg.sv - shared types, output limits and the requantization function for output_requant_stage
package output_pkg;

    localparam int ACC_W = 32;
    localparam int OUT_W = 16;
    localparam int X_W   = 10;
    localparam int Y_W   = 10;
    localparam int CH_W  = 6;

    localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    typedef struct packed {
        logic [X_W-1:0]  x;
        logic [Y_W-1:0]  y;
        logic [CH_W-1:0] ch;
    } coord_t;

    typedef struct packed {
        logic signed [OUT_W-1:0] value;
        logic                    sat;
    } requant_t;

    // One guard bit keeps the half-LSB rounding add from wrapping near the positive limit.
    function automatic requant_t requant(input logic signed [ACC_W-1:0] acc, input int shift);
        logic signed [ACC_W:0] wide;
        logic signed [ACC_W:0] lim_hi;
        logic signed [ACC_W:0] lim_lo;
        requant_t              res;
        lim_hi = (ACC_W+1)'(OUT_MAX);
        lim_lo = (ACC_W+1)'(OUT_MIN);
        wide   = (ACC_W+1)'(acc);
        if (shift > 0) begin
            wide = wide + ((ACC_W+1)'(1) <<< (shift - 1));
        end
        wide = wide >>> shift;
        res.sat = 1'b1;
        if (wide > lim_hi) begin
            res.value = OUT_MAX;
        end else if (wide < lim_lo) begin
            res.value = OUT_MIN;
        end else begin
            res.value = wide[OUT_W-1:0];
            res.sat   = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - parameterized synchronous FIFO with registered head and occupancy count
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == ($clog2(DEPTH)+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    // Empty head reads as zero so the outputs are clean after reset.
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/output_requant_stage.sv
// rtl/output_requant_stage.sv - requantize accumulator results to saturated 16-bit and buffer them on a valid/ready stream
// Optional OUTPUT_RELU_EN: clamps negative results to zero after saturation.
module output_requant_stage
    import output_pkg::*;
#(
    parameter int ACC_WIDTH  = ACC_W,
    parameter int OUT_WIDTH  = OUT_W,
    parameter int SHIFT      = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int X_WIDTH    = X_W,
    parameter int Y_WIDTH    = Y_W,
    parameter int CH_WIDTH   = CH_W
) (
    input  logic                              clk,
    input  logic                              arst_in,
    input  logic [ACC_WIDTH-1:0]              acc_in,
    input  logic                              acc_valid,
    input  logic [X_WIDTH-1:0]                acc_x,
    input  logic [Y_WIDTH-1:0]                acc_y,
    input  logic [CH_WIDTH-1:0]               acc_ch,
    output logic                              acc_ready,
    output logic [OUT_WIDTH-1:0]              out_data,
    output logic [X_WIDTH-1:0]                out_x,
    output logic [Y_WIDTH-1:0]                out_y,
    output logic [CH_WIDTH-1:0]               out_ch,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [15:0]                       sat_count,
    output logic [$clog2(FIFO_DEPTH):0]       fifo_count
);

    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
    localparam int COORD_W = $bits(coord_t);
    localparam int ENTRY_W = OUT_WIDTH + COORD_W;

    requant_t             rq;
    logic                 s1_valid;
    logic                 s1_sat;
    logic [OUT_WIDTH-1:0] s1_value;
    coord_t               s1_coord;
    logic [ENTRY_W-1:0]   head;
    coord_t               head_coord;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 accept;

    always_comb begin
        rq = requant(acc_in, SHIFT);
`ifdef OUTPUT_RELU_EN
        if (rq.value[OUT_WIDTH-1]) begin
            rq.value = '0;
        end
`else
        rq.value = rq.value;
`endif
    end

    // Counting the stage-1 entry as occupied guarantees it a FIFO slot on the next edge.
    assign acc_ready = !fifo_full &&
                       (({1'b0, fifo_count} + {{CNT_W{1'b0}}, s1_valid}) < (CNT_W+1)'(FIFO_DEPTH));
    assign accept    = acc_valid && acc_ready;

    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            s1_valid <= 1'b0;
            s1_sat   <= 1'b0;
            s1_value <= '0;
            s1_coord <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_sat     <= rq.sat;
                s1_value   <= rq.value;
                s1_coord.x  <= acc_x;
                s1_coord.y  <= acc_y;
                s1_coord.ch <= acc_ch;
            end
        end
    end

    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            sat_count <= '0;
        end else if (s1_valid && s1_sat && (sat_count != 16'hFFFF)) begin
            sat_count <= sat_count + 16'd1;
        end
    end

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (arst_in),
        .push      (s1_valid),
        .push_data ({s1_value, s1_coord}),
        .pop       (out_ready),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign head_coord = head[COORD_W-1:0];
    assign out_data   = head[ENTRY_W-1 -: OUT_WIDTH];
    assign out_x      = head_coord.x;
    assign out_y      = head_coord.y;
    assign out_ch     = head_coord.ch;
    assign out_valid  = !fifo_empty;

endmodule
